// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan controller: active-low hex glyphs
// (bit order g..a), the all-dark pattern and the scan-index width helper.
package sseg_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Index width for n digits; never below one bit so a 1-bit index still exists.
    function automatic int clog2(input int n);
        int w;
        int v;
        w = 0;
        v = n - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low 7-segment glyph (g..a).
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_HEX_0;
        case (i_hex)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SSEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 7-segment scanner with per-digit blank/dp/blink, PWM dimming and
// frame-synchronous (tear-free) loading of display contents.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18,
    parameter int DUTY_BITS    = 4,
    parameter int BLINK_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digit_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic [DUTY_BITS-1:0]  duty,
    output logic [7:0]            sseg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int               IDX_W    = clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [REFRESH_BITS-1:0] r_prescale;
    logic [IDX_W-1:0]        r_idx;
    logic [BLINK_BITS-1:0]   r_blink;
    logic                    r_frame_done;

    logic [4*DIGITS-1:0]     r_pend_digit;
    logic [DIGITS-1:0]       r_pend_blank;
    logic [DIGITS-1:0]       r_pend_dp;
    logic [DIGITS-1:0]       r_pend_blink;
    logic [DUTY_BITS-1:0]    r_pend_duty;
    logic                    r_pend_flag;

    logic [4*DIGITS-1:0]     r_act_digit;
    logic [DIGITS-1:0]       r_act_blank;
    logic [DIGITS-1:0]       r_act_dp;
    logic [DIGITS-1:0]       r_act_blink;
    logic [DUTY_BITS-1:0]    r_act_duty;

    logic [7:0]              r_sseg;
    logic [DIGITS-1:0]       r_an;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [DIGITS-1:0]       w_an_sel;
    logic [3:0]              w_digit_masked [DIGITS];
    logic [3:0]              w_sel_digit;
    logic                    w_sel_blank;
    logic                    w_sel_dp;
    logic                    w_sel_blink;
    logic [DUTY_BITS-1:0]    w_phase;
    logic                    w_pwm_on;
    logic                    w_visible;
    logic [6:0]              w_seg;

    assign w_slot_end  = &r_prescale;
    assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale   <= '0;
            r_idx        <= '0;
            r_blink      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_prescale   <= r_prescale + 1'b1;
            r_blink      <= r_blink + 1'b1;
            r_frame_done <= w_frame_end;
            if (w_slot_end) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A load on the boundary cycle lands in pending while the boundary commits
    // the previous pending contents, so the new values wait one full frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_digit <= '0;
            r_pend_blank <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_pend_duty  <= '1;
            r_pend_flag  <= 1'b0;
            r_act_digit  <= '0;
            r_act_blank  <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_act_duty   <= '1;
        end else begin
            r_pend_flag <= load | (r_pend_flag & ~w_frame_end);
            if (load) begin
                r_pend_digit <= digit_in;
                r_pend_blank <= blank_in;
                r_pend_dp    <= dp_in;
                r_pend_blink <= blink_in;
                r_pend_duty  <= duty;
            end
            if (w_frame_end && r_pend_flag) begin
                r_act_digit <= r_pend_digit;
                r_act_blank <= r_pend_blank;
                r_act_dp    <= r_pend_dp;
                r_act_blink <= r_pend_blink;
                r_act_duty  <= r_pend_duty;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_sel
            assign w_an_sel[gi]       = (r_idx == IDX_W'(gi));
            assign w_digit_masked[gi] = r_act_digit[4*gi +: 4] & {4{w_an_sel[gi]}};
        end
    endgenerate

    always_comb begin
        w_sel_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_sel_digit = w_sel_digit | w_digit_masked[k];
        end
    end

    assign w_sel_blank = |(r_act_blank & w_an_sel);
    assign w_sel_dp    = |(r_act_dp    & w_an_sel);
    assign w_sel_blink = |(r_act_blink & w_an_sel);

    assign w_phase   = r_prescale[REFRESH_BITS-1 -: DUTY_BITS];
    assign w_pwm_on  = (w_phase < r_act_duty);
    assign w_visible = w_pwm_on && !w_sel_blank && !(w_sel_blink && r_blink[BLINK_BITS-1]);

    hex_to_sseg u_hex (
        .i_hex (w_sel_digit),
        .o_seg (w_seg)
    );

    // Segments and anodes switch on the same edge to avoid ghosting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sseg <= SSEG_OFF;
            r_an   <= '1;
        end else if (w_visible) begin
            r_sseg <= {~w_sel_dp, w_seg};
            r_an   <= ~w_an_sel;
        end else begin
            r_sseg <= SSEG_OFF;
            r_an   <= '1;
        end
    end

    assign sseg       = r_sseg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
